// File: rtl/int_priority_controller_pkg.sv
// Shared definitions for the prioritising interrupt controller:
// FSM state encoding, default vector layout and an index-width helper.
package int_priority_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    ACK  = 2'd2
  } ipc_state_e;

  localparam int unsigned NR_OF_SOURCES_DEFAULT = 3;
  localparam logic [31:0] VEC_BASE_DEFAULT      = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEFAULT    = 32'h0000_0010;

  // Width of a source index; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/int_priority_controller_if.sv
// CPU / request-register side bus of the interrupt controller.
// master: drives requests, mask writes, IE, Accept, Eret (CPU side).
// slave : the controller; returns IRQ, Vector, ReqClr, InService, Mask.
interface int_priority_controller_if #(
  parameter int unsigned NrOfSources = 3
);
  logic [NrOfSources-1:0] int_req;
  logic                   mask_we;
  logic [NrOfSources-1:0] mask_d;
  logic                   ie;
  logic                   accept;
  logic                   eret;
  logic                   irq;
  logic [31:0]            vector;
  logic [NrOfSources-1:0] req_clr;
  logic [NrOfSources-1:0] in_service;
  logic [NrOfSources-1:0] mask;

  modport master (
    output int_req, mask_we, mask_d, ie, accept, eret,
    input  irq, vector, req_clr, in_service, mask
  );

  modport slave (
    input  int_req, mask_we, mask_d, ie, accept, eret,
    output irq, vector, req_clr, in_service, mask
  );
endinterface

// File: rtl/int_prio_encoder.sv
// Combinational lowest-index-first priority encoder.
// Ports: i_vec (request vector), o_idx_c (index of lowest set bit),
//        o_valid_c (any bit set).
module int_prio_encoder
  import int_priority_controller_pkg::*;
#(
  parameter  int unsigned Width = 3,
  localparam int unsigned IdxW  = idx_width(Width)
) (
  input  logic [Width-1:0] i_vec,
  output logic [IdxW-1:0]  o_idx_c,
  output logic             o_valid_c
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    o_idx_c   = '0;
    o_valid_c = |i_vec;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx_c = IdxW'(i);
    end
  end

endmodule

// File: rtl/int_priority_controller.sv
// Prioritising interrupt controller. Samples the request registers, applies
// the software mask and the in-service level, raises a registered IRQ, and on
// CPU Accept returns the handler vector and pulses a clear to the winner.
// Ports: i_clk, i_rst_n (async active-low), io_bus (slave modport carrying
//        IntReq/MaskWe/MaskD/IE/Accept/Eret in, IRQ/Vector/ReqClr/InService/
//        Mask out).
// Build option: define INT_NESTING_EN to let higher-priority sources nest
// over lower levels already in service; otherwise one level at a time.
module int_priority_controller
  import int_priority_controller_pkg::*;
#(
  parameter int unsigned NrOfSources = NR_OF_SOURCES_DEFAULT,
  parameter logic [31:0] VecBase     = VEC_BASE_DEFAULT,
  parameter logic [31:0] VecStride   = VEC_STRIDE_DEFAULT
) (
  input logic                       i_clk,
  input logic                       i_rst_n,
  int_priority_controller_if.slave  io_bus
);

  localparam int unsigned N    = NrOfSources;
  localparam int unsigned IdxW = idx_width(N);
  localparam logic [N-1:0] ONE = N'(1);

  ipc_state_e       r_state;
  logic [IdxW-1:0]  r_cur_idx;
  logic             r_irq;
  logic [31:0]      r_vector;
  logic [N-1:0]     r_req_clr;
  logic [N-1:0]     r_isr;
  logic [N-1:0]     r_mask;

  logic [N-1:0]     w_above;
  logic [N-1:0]     w_cand;
  logic [IdxW-1:0]  w_win_idx;
  logic             w_win_valid;
  logic [IdxW-1:0]  w_isr_top_idx;
  logic             w_isr_valid;
  logic [N-1:0]     w_cur_oh;
  logic [N-1:0]     w_eret_clr;
  logic [N-1:0]     w_ack_set;
  logic [31:0]      w_vec_next;
  logic             w_cur_live;

  // Winner among eligible requests.
  int_prio_encoder #(.Width(N)) u_cand_enc (
    .i_vec     (w_cand),
    .o_idx_c   (w_win_idx),
    .o_valid_c (w_win_valid)
  );

  // Highest-priority level currently in service.
  int_prio_encoder #(.Width(N)) u_isr_enc (
    .i_vec     (r_isr),
    .o_idx_c   (w_isr_top_idx),
    .o_valid_c (w_isr_valid)
  );

  // Sources allowed to pre-empt the current service level.
`ifdef INT_NESTING_EN
  assign w_above = w_isr_valid ? ((ONE << w_isr_top_idx) - ONE) : '1;
`else
  assign w_above = w_isr_valid ? '0 : '1;
`endif

  assign w_cand     = io_bus.int_req & ~r_mask & w_above;
  assign w_cur_oh   = ONE << r_cur_idx;
  assign w_cur_live = |(w_cand & w_cur_oh);
  assign w_eret_clr = (io_bus.eret && w_isr_valid) ? (ONE << w_isr_top_idx) : '0;
  assign w_ack_set  = (r_state == ACK) ? w_cur_oh : '0;
  assign w_vec_next = VecBase + (32'(r_cur_idx) * VecStride);

  // Handshake FSM with registered outputs, ISR and mask.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cur_idx <= '0;
      r_irq     <= 1'b0;
      r_vector  <= VecBase;
      r_req_clr <= '0;
      r_isr     <= '0;
      r_mask    <= '1;
    end else begin
      r_req_clr <= '0;
      if (io_bus.mask_we) r_mask <= io_bus.mask_d;
      r_isr <= (r_isr & ~w_eret_clr) | w_ack_set;

      case (r_state)
        IDLE: begin
          if (io_bus.ie && w_win_valid) begin
            r_cur_idx <= w_win_idx;
            r_state   <= PEND;
            r_irq     <= 1'b1;
          end
        end
        PEND: begin
          // Losing eligibility withdraws the request; Eret blocks Accept.
          if (!io_bus.ie || !w_cur_live) begin
            r_state <= IDLE;
            r_irq   <= 1'b0;
          end else if (io_bus.accept && !io_bus.eret) begin
            r_state <= ACK;
            r_irq   <= 1'b0;
          end
        end
        ACK: begin
          r_req_clr <= w_cur_oh;
          r_vector  <= w_vec_next;
          r_state   <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.irq        = r_irq;
  assign io_bus.vector     = r_vector;
  assign io_bus.req_clr    = r_req_clr;
  assign io_bus.in_service = r_isr;
  assign io_bus.mask       = r_mask;

endmodule

// File: tb/tb_int_priority_controller.sv
// Self-checking bench for int_priority_controller: directed scenarios plus
// randomized traffic against a behavioural model of the controller.
module tb_int_priority_controller;

  localparam int unsigned N = 3;
  localparam logic [31:0] VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE = 32'h0000_0010;
`ifdef INT_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic clk;
  logic rst_n;

  int_priority_controller_if #(.NrOfSources(N)) bus ();

  int_priority_controller #(
    .NrOfSources (N),
    .VecBase     (VEC_BASE),
    .VecStride   (VEC_STRIDE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  // Stimulus state: request-register contents and CPU-side controls.
  logic [N-1:0] t_req;
  logic         t_mask_we;
  logic [N-1:0] t_mask_d;
  logic         t_ie;
  logic         t_accept;
  logic         t_eret;

  // Behavioural model: pending source, source being acknowledged (-1 = none).
  int           m_pend;
  int           m_ack;
  logic [N-1:0] m_isr;
  logic [N-1:0] m_mask;
  logic         m_irq;
  logic [31:0]  m_vector;
  logic [N-1:0] m_req_clr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend    = -1;
    m_ack     = -1;
    m_isr     = '0;
    m_mask    = '1;
    m_irq     = 1'b0;
    m_vector  = VEC_BASE;
    m_req_clr = '0;
  endtask

  // One clock edge of controller behaviour, from the rules for cand/winner.
  task automatic model_step(input logic [N-1:0] req, input logic mwe, input logic [N-1:0] md,
                            input logic ie, input logic acc, input logic er);
    int           top;
    int           win;
    logic [N-1:0] cand;
    logic [N-1:0] isr_n;
    top = -1;
    for (int i = N - 1; i >= 0; i--) if (m_isr[2'(i)]) top = i;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      bit eligible;
      eligible = (top < 0) || (NEST && (i < top));
      cand[2'(i)] = req[2'(i)] && !m_mask[2'(i)] && eligible;
    end
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (cand[2'(i)]) win = i;

    isr_n = m_isr;
    if (er && top >= 0) isr_n[2'(top)] = 1'b0;
    m_req_clr = '0;
    if (m_ack >= 0) begin
      isr_n[2'(m_ack)]     = 1'b1;
      m_req_clr[2'(m_ack)] = 1'b1;
      m_vector = VEC_BASE + 32'(m_ack) * VEC_STRIDE;
      m_ack    = -1;
    end else if (m_pend < 0) begin
      if (ie && win >= 0) m_pend = win;
    end else if (!ie || !cand[2'(m_pend)]) begin
      m_pend = -1;
    end else if (acc && !er) begin
      m_ack  = m_pend;
      m_pend = -1;
    end
    m_isr = isr_n;
    m_irq = (m_pend >= 0);
    if (mwe) m_mask = md;
  endtask

  task automatic check_all();
    check_eq("irq",     32'(bus.irq),        32'(m_irq));
    check_eq("vector",  bus.vector,          m_vector);
    check_eq("req_clr", 32'(bus.req_clr),    32'(m_req_clr));
    check_eq("isr",     32'(bus.in_service), 32'(m_isr));
    check_eq("mask",    32'(bus.mask),       32'(m_mask));
  endtask

  // Drive one cycle of inputs (request register clears on the ReqClr edge).
  task automatic cycle();
    t_req          = t_req & ~m_req_clr;
    bus.int_req    = t_req;
    bus.mask_we    = t_mask_we;
    bus.mask_d     = t_mask_d;
    bus.ie         = t_ie;
    bus.accept     = t_accept;
    bus.eret       = t_eret;
    model_step(t_req, t_mask_we, t_mask_d, t_ie, t_accept, t_eret);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    t_mask_we = 1'b0;
    t_mask_d  = '0;
    t_accept  = 1'b0;
    t_eret    = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    t_mask_we = 1'b1;
    t_mask_d  = m;
    cycle();
    t_mask_we = 1'b0;
  endtask

  task automatic accept_and_ack();
    t_accept = 1'b1;
    cycle();
    check_eq("ack_irq_low", 32'(bus.irq), 32'd0);
    t_accept = 1'b0;
    cycle();
  endtask

  task automatic eret_once();
    t_eret = 1'b1;
    cycle();
    t_eret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    t_req = '0;
    t_ie  = 1'b0;
    idle_inputs();
    bus.int_req = '0; bus.mask_we = 1'b0; bus.mask_d = '0;
    bus.ie = 1'b0; bus.accept = 1'b0; bus.eret = 1'b0;
    model_reset();
    #12;
    check_eq("rst_irq",     32'(bus.irq),        32'd0);
    check_eq("rst_vector",  bus.vector,          32'h100);
    check_eq("rst_req_clr", 32'(bus.req_clr),    32'd0);
    check_eq("rst_isr",     32'(bus.in_service), 32'd0);
    check_eq("rst_mask",    32'(bus.mask),       32'h7);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single lowest-priority source end to end.
    write_mask(3'b000);
    t_ie  = 1'b1;
    t_req = 3'b100;
    cycle();
    check_eq("s2_irq", 32'(bus.irq), 32'd1);
    accept_and_ack();
    check_eq("s2_req_clr", 32'(bus.req_clr),    32'h4);
    check_eq("s2_vector",  bus.vector,          32'h120);
    check_eq("s2_isr",     32'(bus.in_service), 32'h4);
    eret_once();
    check_eq("s2_isr_ret", 32'(bus.in_service), 32'h0);

    // Masked source 0 lets source 1 win.
    write_mask(3'b001);
    t_req = 3'b011;
    cycle();
    check_eq("s1_irq", 32'(bus.irq), 32'd1);
    accept_and_ack();
    check_eq("s1_vector",  bus.vector,       32'h110);
    check_eq("s1_req_clr", 32'(bus.req_clr), 32'h2);
    eret_once();
    t_req = '0;
    write_mask(3'b000);

    // Nesting: source 0 arriving while source 2 is in service.
    t_req = 3'b100;
    cycle();
    accept_and_ack();
    cycle();
    t_req = 3'b001;
    cycle();
    cycle();
    if (NEST) begin
      check_eq("nest_irq", 32'(bus.irq), 32'd1);
      accept_and_ack();
      check_eq("nest_isr", 32'(bus.in_service), 32'h5);
      cycle();
      eret_once();
      check_eq("eret1_isr", 32'(bus.in_service), 32'h4);
      eret_once();
      check_eq("eret2_isr", 32'(bus.in_service), 32'h0);
      eret_once();
      check_eq("eret3_isr", 32'(bus.in_service), 32'h0);
    end else begin
      check_eq("nonest_irq", 32'(bus.irq), 32'd0);
      eret_once();
      check_eq("nonest_isr", 32'(bus.in_service), 32'h0);
      cycle();
      check_eq("nonest_irq_after", 32'(bus.irq), 32'd1);
      accept_and_ack();
      check_eq("nonest_isr_0", 32'(bus.in_service), 32'h1);
      eret_once();
      eret_once();
      check_eq("eret_empty_isr", 32'(bus.in_service), 32'h0);
    end
    cycle();

    // Accept together with Eret is ignored; a later Accept completes.
    t_req = 3'b010;
    cycle();
    t_accept = 1'b1;
    t_eret   = 1'b1;
    cycle();
    check_eq("ae_irq",     32'(bus.irq),     32'd1);
    check_eq("ae_req_clr", 32'(bus.req_clr), 32'd0);
    t_eret = 1'b0;
    cycle();
    check_eq("ae_irq_ack", 32'(bus.irq), 32'd0);
    t_accept = 1'b0;
    cycle();
    check_eq("ae_req_clr2", 32'(bus.req_clr), 32'h2);
    eret_once();

    // Reset asserted while in ACK aborts without a ReqClr pulse.
    t_req = 3'b001;
    cycle();
    t_accept = 1'b1;
    cycle();
    t_accept = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    t_req = '0;
    #1;
    check_eq("rack_req_clr", 32'(bus.req_clr),    32'd0);
    check_eq("rack_isr",     32'(bus.in_service), 32'd0);
    check_eq("rack_mask",    32'(bus.mask),       32'h7);
    check_eq("rack_vector",  bus.vector,          32'h100);
    @(posedge clk);
    #1;
    check_eq("rack_req_clr2", 32'(bus.req_clr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all();

    // IE dropping while pending withdraws IRQ.
    write_mask(3'b000);
    t_req = 3'b100;
    cycle();
    check_eq("ie_irq_up", 32'(bus.irq), 32'd1);
    t_ie = 1'b0;
    cycle();
    check_eq("ie_irq_down", 32'(bus.irq), 32'd0);
    t_req = '0;
    t_ie  = 1'b1;
    cycle();
    cycle();
    check_eq("ie_no_isr", 32'(bus.in_service), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      t_mask_we = ($urandom_range(15) == 0);
      t_mask_d  = ($urandom_range(3) == 0) ? 3'($urandom) : 3'b000;
      t_req     = t_req | (3'($urandom) & 3'($urandom));
      t_ie      = ($urandom_range(7) != 0);
      t_accept  = 1'($urandom_range(1));
      t_eret    = ($urandom_range(5) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
